// File: rtl/priority_code_player.sv
// Priority code player: buffers 3-bit codes in a small FIFO and shows each one
// as a one-hot line plus 7-segment digit for HOLD cycles, then blanks for GAP cycles.
module priority_code_player #(
   parameter int DEPTH = 4,
   parameter int HOLD  = 8,
   parameter int GAP   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   input  logic [2:0]               code_in,
   input  logic                     code_valid,
   output logic                     code_ready,
   output logic [7:0]               onehot_out,
   output logic [6:0]               seg_out,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     busy
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);
   localparam logic [CW-1:0] HOLD_M1  = CW'(HOLD - 1);
   localparam logic [CW-1:0] GAP_M1   = CW'(GAP - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHOW,
      ST_GAP
   } state_t;

   state_t          state, next_state;
   logic [CW-1:0]   cnt, next_cnt;
   logic [2:0]      cur_code, next_code;
   logic [2:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            push, pop;

   // Full blocks pushes even when a pop lands on the same edge.
   assign code_ready = !rst && (fifo_level < LVL_FULL);
   assign push       = code_valid && code_ready;
   assign busy       = (state != ST_IDLE) || (fifo_level != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= code_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         cur_code <= '0;
      end else begin
         state    <= next_state;
         cnt      <= next_cnt;
         cur_code <= next_code;
      end
   end

   // With ena low nothing advances and no pop is issued.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      next_code  = cur_code;
      pop        = 1'b0;
      if (ena) begin
         case (state)
            ST_IDLE: begin
               if (fifo_level != '0) begin
                  pop        = 1'b1;
                  next_code  = mem[rd_ptr];
                  next_cnt   = HOLD_M1;
                  next_state = ST_SHOW;
               end
            end
            ST_SHOW: begin
               if (cnt == '0) begin
                  next_cnt   = GAP_M1;
                  next_state = ST_GAP;
               end else begin
                  next_cnt = cnt - 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt == '0) begin
                  if (fifo_level != '0) begin
                     pop        = 1'b1;
                     next_code  = mem[rd_ptr];
                     next_cnt   = HOLD_M1;
                     next_state = ST_SHOW;
                  end else begin
                     next_state = ST_IDLE;
                  end
               end else begin
                  next_cnt = cnt - 1'b1;
               end
            end
            default: next_state = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      onehot_out = '0;
      seg_out    = '0;
      if (state == ST_SHOW) begin
         onehot_out = 8'b1 << cur_code;
         case (cur_code)
            3'd0:    seg_out = 7'h3F;
            3'd1:    seg_out = 7'h06;
            3'd2:    seg_out = 7'h5B;
            3'd3:    seg_out = 7'h4F;
            3'd4:    seg_out = 7'h66;
            3'd5:    seg_out = 7'h6D;
            3'd6:    seg_out = 7'h7D;
            default: seg_out = 7'h07;
         endcase
      end
   end

endmodule

// File: doc/priority_code_player.md
Name: priority_code_player

Overview:
- Decodes a stream of 3-bit priority codes back into one-hot lines and a 7-segment digit. It is the inverse of the 8-to-3 priority encoder / 7-seg front end.
- Codes arrive over a valid/ready handshake and are buffered in a small FIFO.
- Each code is "played" for a fixed hold window, followed by a blank gap.
- Sits on the output side of the tile, driving the LEDs/7-seg that show which request was granted.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- HOLD, 8, cycles each decoded code is shown; at least 1.
- GAP, 2, blank cycles after each hold window; at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  playback enable; 0 freezes the FSM and its counters.
- code_in  in  3  priority code to decode (0..7).
- code_valid  in  1  code_in is valid this cycle.
- code_ready  out  1  FIFO can accept a code.
- onehot_out  out  8  one-hot decode of the current code; 0 when not showing.
- seg_out  out  7  segments gfedcba, active-high; digit of the current code; 0 when not showing.
- fifo_level  out  $clog2(DEPTH)+1  number of buffered codes.
- busy  out  1  high when the FSM is not in IDLE or fifo_level is non-zero.

Behaviour:
- Clock and reset: one clock domain; all state is registered.
- Reset value: while rst is high, every output is 0, including code_ready. The FIFO is emptied, the FSM goes to IDLE and the counters clear. Reset mid-play drops the current and all queued codes immediately.
- FIFO write side:
  - code_ready = !rst && (fifo_level < DEPTH).
  - A push happens on an edge where code_valid && code_ready.
  - Pushes are accepted regardless of ena.
  - When full, code_ready=0 even if a pop occurs in the same cycle; there is no same-cycle pass-through at full.
  - If a push and a pop occur in the same cycle while not full, fifo_level is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SHOW, GAP.
- IDLE:
  - If ena && fifo_level!=0: pop the head into cur_code, load the hold counter with HOLD-1, go to SHOW.
  - A code pushed at edge k is popped at edge k+1. onehot_out and seg_out are therefore valid from edge k+1, giving 1-cycle push-to-display latency from an empty/idle state.
- SHOW:
  - onehot_out = 1 << cur_code; seg_out = digit(cur_code).
  - The counter decrements each enabled cycle.
  - At 0, load the gap counter with GAP-1 and go to GAP.
  - SHOW lasts exactly HOLD enabled cycles.
- GAP:
  - onehot_out=0 and seg_out=0 for exactly GAP enabled cycles.
  - At count 0: if fifo_level!=0, pop and go directly to SHOW; otherwise go to IDLE.
- ena=0: the state, counters and outputs hold their values; no pop occurs. On resume, counting continues from where it stopped.
- Segment map (hex, gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
- Outputs: onehot_out and seg_out are registered, or decoded from registered state and cur_code only, so they are glitch-free.
- Output invariant: onehot_out has at most one bit set at all times.
- fifo_level and busy reflect post-edge state.

Test Plan:
- Reset behaviour: rst=1 for 3 cycles with code_valid=1 and code_in=5 -> code_ready=0, fifo_level=0, all outputs 0. After release, code_ready=1 on the next cycle.
- Single code: ena=1, push code 3 at edge k -> onehot_out=0x08 and seg_out=0x4F for edges k+1..k+8 (HOLD=8). Then 0 for 2 cycles, then IDLE with busy=0.
- Back-to-back: push 7,0,5 on consecutive cycles -> shows 0x80 (8 cycles), gap 2, 0x01 (8 cycles), gap 2, 0x20 (8 cycles). fifo_level peaks at 2.
- Full FIFO: hold code_valid=1 with ena=0 -> exactly 4 accepted, code_ready=0 with fifo_level=4. Pop with ena=1 -> code_ready returns 1 the cycle after the pop. Codes play in FIFO order with nothing dropped.
- Pause: deassert ena for 5 cycles during SHOW of code 2 (after 3 hold cycles) -> seg_out stays 0x5B throughout. After resume the code shows for 5 more cycles, 8 enabled cycles in total.
- Reset mid-play: assert rst during SHOW with 2 codes queued -> outputs 0 at once. After release, with no new pushes, busy=0 and nothing plays.
